// File: rtl/key_debounce_pkg.sv
// ============================================================================
// Module   : key_debounce_pkg
// Purpose  : Shared definitions for the key debounce / edge-pulse block:
//            the per-channel FSM state encoding and default parameter values.
// Ports    : none (package)
// Options  : KEY_AUTOREPEAT_EN is consumed by key_debounce_channel
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_debounce_pkg;

    // Per-channel debounce FSM. The MSB equals "key is (or was) down", so the
    // stable states S_UP/S_DOWN differ from their debounce states only in bit 0.
    typedef enum logic [1:0] {
        S_UP       = 2'b00,
        S_DEB_DOWN = 2'b01,
        S_DOWN     = 2'b10,
        S_DEB_UP   = 2'b11
    } state_t;

    // Defaults sized for a 50 MHz clock.
    localparam int C_DEF_NUM_KEYS        = 2;
    localparam int C_DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms
    localparam int C_DEF_CNT_W           = 25;
    localparam int C_DEF_REPEAT_DELAY    = 25000000;  // 500 ms
    localparam int C_DEF_REPEAT_PERIOD   = 5000000;   // 100 ms

endpackage : key_debounce_pkg

`default_nettype wire

// File: rtl/key_debounce_channel.sv
// ============================================================================
// Module   : key_debounce_channel
// Purpose  : One key channel: 2-flop synchronizer, debounce FSM with a
//            saturating cycle counter, registered level and one-cycle
//            press/release pulses.
// Ports    : clk_i      - system clock (rising edge)
//            rst_n_i    - synchronous active-low reset
//            key_raw_i  - raw asynchronous key pin, 0 = pressed
//            level_o    - debounced level, 1 = released
//            press_o    - one-cycle pulse on accepted 1->0
//            release_o  - one-cycle pulse on accepted 0->1
// Options  : `define KEY_AUTOREPEAT_EN adds periodic press pulses while held
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = C_DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = C_DEF_CNT_W,
    parameter int REPEAT_DELAY    = C_DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = C_DEF_REPEAT_PERIOD
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    // Terminal counts: the counter stops here, so it can never wrap.
    localparam logic [CNT_W-1:0] C_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Every cycle count must be at least 1 and its terminal value must fit
    // in the counter.
    if ((DEBOUNCE_CYCLES < 1) || (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1) ||
        (((DEBOUNCE_CYCLES - 1) >> CNT_W) != 0) ||
        (((REPEAT_DELAY - 1) >> CNT_W) != 0) ||
        (((REPEAT_PERIOD - 1) >> CNT_W) != 0)) begin : g_cfg_check
        $error("key_debounce_channel: cycle counts out of range for CNT_W");
    end

    logic             meta_q;
    logic             sync_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] C_RPT_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] C_RPT_PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt_cnt_q;
    // Set after the first repeat pulse: later pulses use the shorter period.
    logic             rpt_armed_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            meta_q    <= 1'b1;
            sync_q    <= 1'b1;
            state_q   <= S_UP;
            cnt_q     <= '0;
            level_q   <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
`endif
        end else begin
            meta_q    <= key_raw_i;
            sync_q    <= meta_q;
            press_q   <= 1'b0;
            release_q <= 1'b0;

            case (state_q)
                S_UP: begin
                    if (!sync_q) begin
                        state_q <= S_DEB_DOWN;
                        cnt_q   <= '0;
                    end
                end

                S_DEB_DOWN: begin
                    if (sync_q) begin
                        // Bounce: the low level did not last long enough.
                        state_q <= S_UP;
                    end else if (cnt_q == C_DEB_LAST) begin
                        state_q <= S_DOWN;
                        level_q <= 1'b0;
                        press_q <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                        rpt_cnt_q   <= '0;
                        rpt_armed_q <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_DOWN: begin
                    if (sync_q) begin
                        state_q <= S_DEB_UP;
                        cnt_q   <= '0;
                    end
`ifdef KEY_AUTOREPEAT_EN
                    else if (rpt_cnt_q == (rpt_armed_q ? C_RPT_PER_LAST
                                                       : C_RPT_DLY_LAST)) begin
                        press_q     <= 1'b1;
                        rpt_cnt_q   <= '0;
                        rpt_armed_q <= 1'b1;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + CNT_W'(1);
                    end
`endif
                end

                S_DEB_UP: begin
                    // The repeat counter is left untouched here so that a
                    // rejected release bounce resumes the repeat cadence.
                    if (!sync_q) begin
                        state_q <= S_DOWN;
                    end else if (cnt_q == C_DEB_LAST) begin
                        state_q   <= S_UP;
                        level_q   <= 1'b1;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: state_q <= S_UP;
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule : key_debounce_channel

`default_nettype wire

// File: rtl/key_debounce_edge.sv
// ============================================================================
// Module   : key_debounce_edge
// Purpose  : Debounces the active-low DE0-Nano-SoC KEY pins and produces a
//            clean level plus one-cycle press/release pulses per key.
//            Each key is handled by an independent key_debounce_channel.
// Ports    : CLOCK_50    - system clock (rising edge)
//            RESET_N     - synchronous active-low reset
//            KEY         - raw key pins [NUM_KEYS], 0 = pressed
//            key_level   - debounced level [NUM_KEYS], 1 = released
//            key_press   - one-cycle pulse per accepted press [NUM_KEYS]
//            key_release - one-cycle pulse per accepted release [NUM_KEYS]
// Options  : `define KEY_AUTOREPEAT_EN enables auto-repeat press pulses
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce_edge
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS        = C_DEF_NUM_KEYS,
    parameter int DEBOUNCE_CYCLES = C_DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = C_DEF_CNT_W,
    parameter int REPEAT_DELAY    = C_DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = C_DEF_REPEAT_PERIOD
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk_i     (CLOCK_50),
            .rst_n_i   (RESET_N),
            .key_raw_i (KEY[g]),
            .level_o   (key_level[g]),
            .press_o   (key_press[g]),
            .release_o (key_release[g])
        );
    end

endmodule : key_debounce_edge

`default_nettype wire

// File: tb/tb_key_debounce_edge.sv
// ============================================================================
// Module   : tb_key_debounce_edge
// Purpose  : Self-checking bench for key_debounce_edge. Stimulus pushes the
//            expected pulse events (edge number, press, release, level) into
//            a queue; a monitor pops one entry per observed pulse cycle.
//            Edge numbering: edge_cnt is the count of rising edges so far.
// Options  : expectations follow KEY_AUTOREPEAT_EN when it is defined
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_debounce_edge;

    localparam int D  = 4;   // DEBOUNCE_CYCLES
    localparam int RD = 10;  // REPEAT_DELAY
    localparam int RP = 3;   // REPEAT_PERIOD

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] key;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;

    always #5 clk = ~clk;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    key_debounce_edge #(
        .NUM_KEYS        (2),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (8),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLOCK_50    (clk),
        .RESET_N     (rst_n),
        .KEY         (key),
        .key_level   (lvl),
        .key_press   (prs),
        .key_release (rel)
    );

    typedef struct {
        int unsigned cyc;
        logic [1:0]  prs;
        logic [1:0]  rel;
        logic [1:0]  lvl;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: every cycle with any pulse must match the next expected event.
    always @(negedge clk) begin
        if ((prs | rel) != 2'b00) begin
            exp_t e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: edge=%0d press=%b release=%b, required no pulse",
                         edge_cnt, prs, rel);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != edge_cnt || e.prs != prs || e.rel != rel || e.lvl != lvl) begin
                    bad++;
                    $display("FAIL pulse_event: got edge=%0d press=%b release=%b level=%b, required edge=%0d press=%b release=%b level=%b",
                             edge_cnt, prs, rel, lvl, e.cyc, e.prs, e.rel, e.lvl);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b required %b at edge %0d", name, got, want, edge_cnt);
        end
    endtask

    // Expected events for keys in mask: raw press first sampled at edge s0,
    // raw release first sampled at edge r. Other keys are assumed released.
    task automatic expect_seq(input logic [1:0] mask, input int unsigned s0,
                              input int unsigned r);
        exp_t e;
        e.cyc = s0 + D + 2;
        e.prs = mask;
        e.rel = 2'b00;
        e.lvl = ~mask;
        exp_q.push_back(e);
`ifdef KEY_AUTOREPEAT_EN
        begin
            // The FSM still sees the key held at edge r+1.
            int unsigned t;
            t = s0 + D + 2 + RD;
            while (t <= r + 1) begin
                e.cyc = t;
                exp_q.push_back(e);
                t += RP;
            end
        end
`endif
        e.cyc = r + D + 2;
        e.prs = 2'b00;
        e.rel = mask;
        e.lvl = 2'b11;
        exp_q.push_back(e);
    endtask

    // Clean press of the keys in mask held for h cycles, then released.
    // Must be called at a falling edge.
    task automatic hold_key(input logic [1:0] mask, input int h);
        int unsigned n;
        n = edge_cnt;
        expect_seq(mask, n + 1, n + h + 1);
        key = ~mask;
        repeat (D + 2) @(negedge clk);
        chk("level_before_press_accept", lvl, 2'b11);
        @(negedge clk);
        chk("level_after_press_accept", lvl, ~mask);
        repeat (h - D - 3) @(negedge clk);
        key = 2'b11;
        repeat (D + 2) @(negedge clk);
        chk("level_before_release_accept", lvl, ~mask);
        @(negedge clk);
        chk("level_after_release_accept", lvl, 2'b11);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int unsigned n;
        rst_n = 1'b0;
        key   = 2'b11;
        repeat (3) @(negedge clk);
        chk("reset_level", lvl, 2'b11);
        chk("reset_press", prs, 2'b00);
        chk("reset_release", rel, 2'b00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean press on KEY[0], held 20 cycles.
        hold_key(2'b01, 20);

        // Bounce rejection on KEY[0]: 0,1,0,1 every 2 cycles, then settle low.
        n = edge_cnt;
        expect_seq(2'b01, n + 9, n + 21);
        key = 2'b10; repeat (2) @(negedge clk);
        key = 2'b11; repeat (2) @(negedge clk);
        key = 2'b10; repeat (2) @(negedge clk);
        key = 2'b11; repeat (2) @(negedge clk);
        key = 2'b10;
        repeat (D + 2) @(negedge clk);
        chk("bounce_level_hold", lvl, 2'b11);
        @(negedge clk);
        chk("bounce_level_accept", lvl, 2'b10);
        repeat (5) @(negedge clk);
        key = 2'b11;
        repeat (D + 8) @(negedge clk);

        // Both keys pressed and released on the same edges.
        hold_key(2'b11, 15);

        // Reset for 2 cycles in the middle of a KEY[0] press debounce.
        n = edge_cnt;
        key = 2'b10;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_mid_level", lvl, 2'b11);
        chk("reset_mid_press", prs, 2'b00);
        rst_n = 1'b1;
        expect_seq(2'b01, n + 6, n + 21);
        repeat (D + 2) @(negedge clk);
        chk("after_reset_level_hold", lvl, 2'b11);
        @(negedge clk);
        chk("after_reset_level_accept", lvl, 2'b10);
        repeat (8) @(negedge clk);
        key = 2'b11;
        repeat (D + 8) @(negedge clk);

        // Long hold of KEY[1] (auto-repeat window).
        hold_key(2'b10, 30);

        repeat (5) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_pulses: %0d expected events not seen, required 0",
                     exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_key_debounce_edge

`default_nettype wire
